// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: LSU-to-data-memory access FSM; define MISALIGN_CHK_EN to trap misaligned requests
module lsu_mem_ctrl #(
  parameter int LATENCY = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_cs,
  input  logic        req_wr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam logic [8:0] TMO = 9'(TIMEOUT);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic wr_q;
  logic [3:0] mask_q;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
  logic err_q, err_d, cap, hit, tmo, mis;
`ifdef MISALIGN_CHK_EN
  assign mis = (req_mask == 4'hf && req_addr[1:0] != 2'b00) || ((req_mask == 4'h3 || req_mask == 4'hc) && req_addr[0]);
`else
  assign mis = 1'b0;
`endif
  assign cap = state_q == IDLE && !req_cs;
  assign hit = state_q == BUSY && cnt_q >= LAT_M1 && mem_ready;
  assign tmo = state_q == BUSY && !hit && ({1'b0, cnt_q} + 9'd1 >= TMO);
  // next state, busy-cycle counter and completion status latched on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: if (cap) begin
        state_d = mis ? DONE : BUSY;
        cnt_d = '0;
        err_d = mis;
        rdata_d = mis ? '0 : rdata_q;
      end
      BUSY: begin
        cnt_d = ({1'b0, cnt_q} == TMO) ? cnt_q : cnt_q + 8'd1;
        if (hit || tmo) begin
          state_d = DONE;
          err_d = tmo;
          rdata_d = (hit && wr_q) ? mem_rdata : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counter, captured request and returned data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b1;
      mask_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      if (cap) begin
        wr_q <= req_wr;
        mask_q <= req_mask;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  assign mem_cs = state_q != BUSY;
  assign mem_wr = wr_q;
  assign mem_mask = mask_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign stall = rst && (cap || state_q == BUSY);
  assign valid = state_q == DONE;
  assign rdata = rdata_q;
  assign err = err_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: randomized scoreboard bench for lsu_mem_ctrl against a transaction-level model
module tb_lsu_mem_ctrl;
  localparam int LAT = 2;
  localparam int TMO = 20;
`ifdef MISALIGN_CHK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst, req_cs, req_wr, mem_ready;
  logic [3:0] req_mask;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic mem_cs, mem_wr, stall, valid, err;
  logic [3:0] mem_mask;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic e_cs, e_stall, e_wr;
  logic [3:0] e_mask;
  logic [31:0] e_addr, e_wdata, e_rdata;
  bit chk_en = 1'b0;
  int cyc = 0;
  int checks = 0, errors = 0;
  typedef struct {int cyc; logic err; logic [31:0] rdata;} txn_t;
  txn_t sb[$];

  lsu_mem_ctrl #(.LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_cs(req_cs), .req_wr(req_wr), .req_mask(req_mask),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .stall(stall), .valid(valid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, cyc, a, e);
    end
  endfunction

  function automatic bit misaligned(logic [3:0] m, logic [31:0] a);
    return MIS_EN && ((m == 4'hf && a % 4 != 0) || ((m == 4'h3 || m == 4'hc) && a % 2 != 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic noise();
    req_wr = 1'($urandom);
    req_mask = 4'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    mem_rdata = $urandom;
    mem_ready = 1'($urandom);
  endtask

  task automatic bus_reset();
    e_wr = 1'b1;
    e_mask = '0;
    e_addr = '0;
    e_wdata = '0;
    e_rdata = '0;
  endtask

  // one access: idle gap, capture, memory wait of d ready-delay cycles, completion
  task automatic txn(int gap, bit wr, logic [3:0] mask, logic [31:0] addr, logic [31:0] wdata,
                     int d, int rst_at, bit done_cs, logic [31:0] rv);
    int kq, k_end, cap;
    bit tmo;
    logic [31:0] rd;
    repeat (gap) begin
      step(); noise(); req_cs = 1'b1; e_cs = 1'b1; e_stall = 1'b0;
    end
    step(); noise();
    req_cs = 1'b0; req_wr = wr; req_mask = mask; req_addr = addr; req_wdata = wdata;
    e_cs = 1'b1; e_stall = 1'b1;
    cap = cyc;
    if (misaligned(mask, addr)) begin
      sb.push_back('{cap + 1, 1'b1, 32'h0});
      step(); noise(); req_cs = 1'($urandom);
      e_wr = wr; e_mask = mask; e_addr = addr; e_wdata = wdata; e_rdata = '0;
      e_cs = 1'b1; e_stall = 1'b0;
      return;
    end
    kq = d > LAT - 1 ? d : LAT - 1;
    tmo = kq > TMO - 1;
    k_end = tmo ? TMO - 1 : kq;
    rd = (wr && !tmo) ? rv : 32'h0;
    if (rst_at < 0 || rst_at > k_end) sb.push_back('{cap + k_end + 2, tmo, rd});
    for (int k = 0; k <= k_end; k++) begin
      step(); noise(); req_cs = 1'($urandom);
      e_wr = wr; e_mask = mask; e_addr = addr; e_wdata = wdata; e_cs = 1'b0; e_stall = 1'b1;
      mem_ready = (k >= d) || (k < LAT - 1 && 1'($urandom));
      if (k == k_end) mem_rdata = rv;
      if (k == rst_at) begin
        rst = 1'b0; e_stall = 1'b0;
        step(); noise(); req_cs = 1'b1;
        bus_reset(); e_cs = 1'b1; e_stall = 1'b0;
        return;
      end
    end
    step(); noise(); req_cs = done_cs;
    e_cs = 1'b1; e_stall = 1'b0; e_rdata = rd;
  endtask

  // monitor: per-cycle bus/stall checks and scoreboard pop on each valid pulse
  always @(negedge clk) begin
    txn_t t;
    logic ev;
    if (chk_en) begin
      chk("mem_cs", 32'(mem_cs), 32'(e_cs));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_mask", 32'(mem_mask), 32'(e_mask));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rdata", rdata, e_rdata);
      ev = sb.size() > 0 && sb[0].cyc == cyc;
      chk("valid", 32'(valid), 32'(ev));
      if (ev) begin
        t = sb.pop_front();
        chk("err", 32'(err), 32'(t.err));
        chk("rdata_ret", rdata, t.rdata);
      end else chk("err_idle", 32'(err), 32'(0));
    end
  end

  initial begin
    rst = 1'b0; noise(); req_cs = 1'b1; mem_ready = 1'b0;
    e_cs = 1'b1; e_stall = 1'b0; bus_reset();
    @(posedge clk); #1;
    chk_en = 1'b1;
    req_cs = 1'b0;
    @(posedge clk); #1;
    req_cs = 1'b1;
    txn(1, 1'b1, 4'hf, 32'h100, 32'h0, 0, -1, 1'b1, 32'hDEADBEEF);
    txn(1, 1'b0, 4'h1, 32'h200, 32'hAA, 5, -1, 1'b1, $urandom);
    txn(1, 1'b1, 4'hf, 32'h300, 32'h0, 1000, -1, 1'b0, $urandom);
    txn(0, 1'b1, 4'hf, 32'h304, 32'h0, 2, -1, 1'b1, $urandom);
    txn(1, 1'b1, 4'hf, 32'h400, 32'h0, 3, 0, 1'b1, $urandom);
    txn(1, 1'b1, 4'hf, 32'h102, 32'h0, 0, -1, 1'b1, $urandom);
    for (int i = 0; i < 200; i++)
      txn($urandom_range(0, 2), 1'($urandom), 4'($urandom), $urandom, $urandom,
          ($urandom_range(0, 7) == 0) ? $urandom_range(15, 30) : $urandom_range(0, 9),
          ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1,
          1'($urandom), $urandom);
    repeat (3) begin
      step(); noise(); req_cs = 1'b1; e_cs = 1'b1; e_stall = 1'b0;
    end
    chk("drain", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
